// File: rtl/letc_core_pkg.sv
// Shared definitions for the LETC core: pipeline stage indices and the
// hazard controller's sfence sequencing states.
package letc_core_pkg;

    localparam int STAGE_F1 = 0;
    localparam int STAGE_F2 = 1;
    localparam int STAGE_D  = 2;
    localparam int STAGE_E1 = 3;
    localparam int STAGE_E2 = 4;
    localparam int STAGE_W  = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TLB_FLUSH = 2'd1,
        REFETCH   = 2'd2
    } hazard_fsm_e;

endpackage : letc_core_pkg

// File: rtl/letc_core_sfence_seq.sv
// sfence.vma sequencer: waits for both TLB invalidate acknowledgements, then
// issues a one-cycle refetch redirect unless a trap aborted the sequence.
module letc_core_sfence_seq
    import letc_core_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sfence,
    input  logic [31:0] i_sfence_next_pc,
    input  logic        i_trap,
    input  logic        i_itlb_flush_done,
    input  logic        i_dtlb_flush_done,
    output hazard_fsm_e o_state,
    output logic        o_tlb_flush_req,
    output logic        o_refetch_valid,
    output logic [31:0] o_refetch_pc
);

    hazard_fsm_e state_q, state_d;
    logic        itlb_done_q, itlb_done_d;
    logic        dtlb_done_q, dtlb_done_d;
    logic        abort_refetch_q, abort_refetch_d;
    logic [31:0] refetch_pc_q, refetch_pc_d;

    // NOTE: non-blocking assignments only here, so every register samples
    // the pre-edge value of every other register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= IDLE;
            itlb_done_q     <= 1'b0;
            dtlb_done_q     <= 1'b0;
            abort_refetch_q <= 1'b0;
            refetch_pc_q    <= 32'h0;
        end else begin
            state_q         <= state_d;
            itlb_done_q     <= itlb_done_d;
            dtlb_done_q     <= dtlb_done_d;
            abort_refetch_q <= abort_refetch_d;
            refetch_pc_q    <= refetch_pc_d;
        end
    end

    logic itlb_seen, dtlb_seen;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d         = state_q;
        itlb_done_d     = itlb_done_q;
        dtlb_done_d     = dtlb_done_q;
        abort_refetch_d = abort_refetch_q;
        refetch_pc_d    = refetch_pc_q;
        itlb_seen       = itlb_done_q | i_itlb_flush_done;
        dtlb_seen       = dtlb_done_q | i_dtlb_flush_done;

        unique case (state_q)
            IDLE: begin
                if (i_sfence && !i_trap) begin
                    state_d         = TLB_FLUSH;
                    refetch_pc_d    = i_sfence_next_pc;
                    itlb_done_d     = 1'b0;
                    dtlb_done_d     = 1'b0;
                    abort_refetch_d = 1'b0;
                end
            end
            TLB_FLUSH: begin
                itlb_done_d = itlb_seen;
                dtlb_done_d = dtlb_seen;
                if (i_trap) abort_refetch_d = 1'b1;
                // A done pulse counts in the cycle it arrives, not a cycle later.
                if (itlb_seen && dtlb_seen) begin
                    state_d         = (abort_refetch_q || i_trap) ? IDLE : REFETCH;
                    itlb_done_d     = 1'b0;
                    dtlb_done_d     = 1'b0;
                    abort_refetch_d = 1'b0;
                end
            end
            REFETCH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_state         = state_q;
    assign o_tlb_flush_req = (state_q == TLB_FLUSH);
    assign o_refetch_valid = (state_q == REFETCH);
    assign o_refetch_pc    = refetch_pc_q;

endmodule : letc_core_sfence_seq

// File: rtl/letc_core_hazard_ctrl.sv
// Central pipeline hazard controller: per-stage stall/flush, front-end redirect
// and sfence.vma sequencing. LETC_HAZARD_PERF_COUNTERS_EN adds perf counters.
module letc_core_hazard_ctrl
    import letc_core_pkg::*;
#(
    parameter int NUM_STAGES = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_STAGES-1:0] i_stage_ready,
    output logic [NUM_STAGES-1:0] o_stage_stall,
    output logic [NUM_STAGES-1:0] o_stage_flush,
    input  logic                  i_e1_branch_taken,
    input  logic [31:0]           i_e1_branch_target,
    input  logic                  i_e2_trap,
    input  logic [31:0]           i_e2_trap_pc,
    input  logic                  i_e2_sfence,
    input  logic [31:0]           i_e2_sfence_next_pc,
    output logic                  o_tlb_flush_req,
    input  logic                  i_itlb_flush_done,
    input  logic                  i_dtlb_flush_done,
    output logic                  o_redirect_valid,
    output logic [31:0]           o_redirect_pc
`ifdef LETC_HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0]           o_perf_stall_cycles,
    output logic [15:0]           o_perf_flush_events
`endif
);

    hazard_fsm_e state;
    logic        refetch_valid;
    logic [31:0] refetch_pc;

    letc_core_sfence_seq u_sfence_seq (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_sfence          (i_e2_sfence),
        .i_sfence_next_pc  (i_e2_sfence_next_pc),
        .i_trap            (i_e2_trap),
        .i_itlb_flush_done (i_itlb_flush_done),
        .i_dtlb_flush_done (i_dtlb_flush_done),
        .o_state           (state),
        .o_tlb_flush_req   (o_tlb_flush_req),
        .o_refetch_valid   (refetch_valid),
        .o_refetch_pc      (refetch_pc)
    );

    logic sfence_acc, branch_acc, refetch_now;

    assign sfence_acc  = i_e2_sfence & ~i_e2_trap & (state == IDLE);
    assign branch_acc  = i_e1_branch_taken & ~i_e2_trap & ~sfence_acc;
    assign refetch_now = refetch_valid & ~i_e2_trap;

    logic [NUM_STAGES-1:0] stall_raw;
    logic                  downstream_busy;

    always_comb begin
        stall_raw       = '0;
        o_stage_flush   = '0;
        downstream_busy = 1'b0;
        // Walk from W back to F1 so each stage sees the OR of all later not-ready bits.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            stall_raw[k]    = downstream_busy;
            downstream_busy = downstream_busy | ~i_stage_ready[k];
        end
        stall_raw[STAGE_F1] = stall_raw[STAGE_F1] | (state != IDLE);

        for (int k = 0; k < NUM_STAGES; k++) begin
            o_stage_flush[k] = (i_e2_trap  && (k <= STAGE_E2))
                            || (sfence_acc && (k <= STAGE_E1))
                            || (branch_acc && (k <= STAGE_D));
        end
    end

    assign o_stage_stall    = stall_raw & ~o_stage_flush;
    assign o_redirect_valid = i_e2_trap | refetch_now | branch_acc;
    assign o_redirect_pc    = i_e2_trap   ? i_e2_trap_pc :
                              refetch_now ? refetch_pc :
                              branch_acc  ? i_e1_branch_target : 32'h0;

`ifdef LETC_HAZARD_PERF_COUNTERS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_perf_stall_cycles <= 32'h0;
            o_perf_flush_events <= 16'h0;
        end else begin
            if (o_stage_stall[STAGE_F1] && (o_perf_stall_cycles != '1))
                o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
            if ((|o_stage_flush) && (o_perf_flush_events != '1))
                o_perf_flush_events <= o_perf_flush_events + 16'd1;
        end
    end
`else
    // Counters absent: no extra state in this build.
`endif

endmodule : letc_core_hazard_ctrl

// File: tb/tb_letc_core_hazard_ctrl.sv
// Self-checking bench for letc_core_hazard_ctrl: directed scenarios followed by
// randomized stimulus compared against a behavioural model of the hazard rules.
module tb_letc_core_hazard_ctrl;

    typedef struct {
        logic [5:0]  ready;
        logic        br;
        logic [31:0] br_tgt;
        logic        trap;
        logic [31:0] trap_pc;
        logic        sf;
        logic [31:0] sf_pc;
        logic        idone;
        logic        ddone;
    } stim_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [5:0]  i_stage_ready = 6'h3f;
    logic [5:0]  o_stage_stall, o_stage_flush;
    logic        i_e1_branch_taken = 1'b0;
    logic [31:0] i_e1_branch_target = 32'h0;
    logic        i_e2_trap = 1'b0;
    logic [31:0] i_e2_trap_pc = 32'h0;
    logic        i_e2_sfence = 1'b0;
    logic [31:0] i_e2_sfence_next_pc = 32'h0;
    logic        o_tlb_flush_req;
    logic        i_itlb_flush_done = 1'b0;
    logic        i_dtlb_flush_done = 1'b0;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    always #5 i_clk = ~i_clk;

    letc_core_hazard_ctrl #(.NUM_STAGES(6)) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_stage_ready       (i_stage_ready),
        .o_stage_stall       (o_stage_stall),
        .o_stage_flush       (o_stage_flush),
        .i_e1_branch_taken   (i_e1_branch_taken),
        .i_e1_branch_target  (i_e1_branch_target),
        .i_e2_trap           (i_e2_trap),
        .i_e2_trap_pc        (i_e2_trap_pc),
        .i_e2_sfence         (i_e2_sfence),
        .i_e2_sfence_next_pc (i_e2_sfence_next_pc),
        .o_tlb_flush_req     (o_tlb_flush_req),
        .i_itlb_flush_done   (i_itlb_flush_done),
        .i_dtlb_flush_done   (i_dtlb_flush_done),
        .o_redirect_valid    (o_redirect_valid),
        .o_redirect_pc       (o_redirect_pc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of the sfence sequence: "waiting for TLB acks", "refetch due next".
    logic        m_waiting, m_refetch_due, m_got_i, m_got_d, m_aborted;
    logic [31:0] m_resume_pc;

    task automatic model_reset();
        m_waiting     = 1'b0;
        m_refetch_due = 1'b0;
        m_got_i       = 1'b0;
        m_got_d       = 1'b0;
        m_aborted     = 1'b0;
        m_resume_pc   = 32'h0;
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s.ready = 6'h3f; s.br = 1'b0; s.br_tgt = 32'h0; s.trap = 1'b0; s.trap_pc = 32'h0;
        s.sf = 1'b0; s.sf_pc = 32'h0; s.idone = 1'b0; s.ddone = 1'b0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_stage_ready       = s.ready;
        i_e1_branch_taken   = s.br;
        i_e1_branch_target  = s.br_tgt;
        i_e2_trap           = s.trap;
        i_e2_trap_pc        = s.trap_pc;
        i_e2_sfence         = s.sf;
        i_e2_sfence_next_pc = s.sf_pc;
        i_itlb_flush_done   = s.idone;
        i_dtlb_flush_done   = s.ddone;
    endtask

    // One clock: drive at negedge, compare 1 ns later, advance the model at posedge.
    task automatic step(input stim_t s, output logic [5:0] ob_stall, output logic [5:0] ob_flush,
                        output logic ob_rv, output logic [31:0] ob_pc, output logic ob_req);
        logic        busy, sf_ok, br_ok, rv;
        logic [5:0]  ef, es;
        logic [31:0] epc;
        @(negedge i_clk);
        apply(s);
        #1;
        busy  = m_waiting | m_refetch_due;
        sf_ok = s.sf && !s.trap && !busy;
        br_ok = s.br && !s.trap && !sf_ok;
        ef = s.trap ? 6'b011111 : sf_ok ? 6'b001111 : br_ok ? 6'b000111 : 6'b000000;
        for (int k = 0; k < 6; k++) begin
            es[k] = 1'b0;
            for (int j = k + 1; j < 6; j++) if (!s.ready[j]) es[k] = 1'b1;
        end
        if (busy) es[0] = 1'b1;
        es = es & ~ef;
        rv  = s.trap || br_ok || m_refetch_due;
        epc = s.trap ? s.trap_pc : m_refetch_due ? m_resume_pc : s.br_tgt;
        ob_stall = o_stage_stall; ob_flush = o_stage_flush;
        ob_rv = o_redirect_valid; ob_pc = o_redirect_pc; ob_req = o_tlb_flush_req;
        check("stall", {26'h0, o_stage_stall}, {26'h0, es});
        check("flush", {26'h0, o_stage_flush}, {26'h0, ef});
        check("tlb_req", {31'h0, o_tlb_flush_req}, {31'h0, m_waiting});
        check("redir_valid", {31'h0, o_redirect_valid}, {31'h0, rv});
        if (rv) check("redir_pc", o_redirect_pc, epc);
        @(posedge i_clk);
        if (m_refetch_due) begin
            m_refetch_due = 1'b0;
        end else if (m_waiting) begin
            m_got_i   = m_got_i | s.idone;
            m_got_d   = m_got_d | s.ddone;
            m_aborted = m_aborted | s.trap;
            if (m_got_i && m_got_d) begin
                m_waiting     = 1'b0;
                m_refetch_due = !m_aborted;
            end
        end else if (sf_ok) begin
            m_waiting   = 1'b1;
            m_resume_pc = s.sf_pc;
            m_got_i     = 1'b0;
            m_got_d     = 1'b0;
            m_aborted   = 1'b0;
        end
    endtask

    initial begin
        stim_t       s;
        logic [5:0]  st, fl;
        logic        rv, rq;
        logic [31:0] pc;

        model_reset();
        apply(quiet());
        #12;
        check("rst_flush", {26'h0, o_stage_flush}, 32'h0);
        check("rst_req", {31'h0, o_tlb_flush_req}, 32'h0);
        check("rst_rv", {31'h0, o_redirect_valid}, 32'h0);
        check("rst_pc", o_redirect_pc, 32'h0);
        check("rst_stall", {26'h0, o_stage_stall}, 32'h0);
        i_stage_ready = 6'b111011;
        #1;
        check("rst_stall_follow", {26'h0, o_stage_stall}, 32'h0000_0003);
        i_stage_ready = 6'h3f;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // E2 not ready for two cycles
        step(quiet(), st, fl, rv, pc, rq);
        for (int c = 0; c < 2; c++) begin
            s = quiet(); s.ready[4] = 1'b0;
            step(s, st, fl, rv, pc, rq);
            check("tp_e2_stall", {26'h0, st}, 32'h0000_000f);
            check("tp_e2_noflush", {26'h0, fl}, 32'h0);
        end
        step(quiet(), st, fl, rv, pc, rq);
        check("tp_stall_release", {26'h0, st}, 32'h0);

        // Branch alone, then trap + branch
        s = quiet(); s.br = 1'b1; s.br_tgt = 32'h8000_0100;
        step(s, st, fl, rv, pc, rq);
        check("tp_br_flush", {26'h0, fl}, 32'h0000_0007);
        check("tp_br_pc", pc, 32'h8000_0100);
        s.trap = 1'b1; s.trap_pc = 32'h0000_0200;
        step(s, st, fl, rv, pc, rq);
        check("tp_trap_flush", {26'h0, fl}, 32'h0000_001f);
        check("tp_trap_pc", pc, 32'h0000_0200);

        // Sfence: DTLB done at +2, ITLB done at +4, refetch at +5
        s = quiet(); s.sf = 1'b1; s.sf_pc = 32'h8000_0044;
        step(s, st, fl, rv, pc, rq);
        check("tp_sf_flush", {26'h0, fl}, 32'h0000_000f);
        for (int c = 1; c <= 5; c++) begin
            s = quiet(); s.ddone = (c == 2); s.idone = (c == 4);
            step(s, st, fl, rv, pc, rq);
            check("tp_sf_req", {31'h0, rq}, {31'h0, (c <= 4)});
            check("tp_sf_f1stall", {31'h0, st[0]}, 32'h1);
            if (c == 5) check("tp_sf_refetch_pc", pc, 32'h8000_0044);
        end
        step(quiet(), st, fl, rv, pc, rq);
        check("tp_sf_idle", {31'h0, rv}, 32'h0);

        // Trap during TLB_FLUSH aborts the refetch
        s = quiet(); s.sf = 1'b1; s.sf_pc = 32'h8000_1004;
        step(s, st, fl, rv, pc, rq);
        s = quiet(); s.trap = 1'b1; s.trap_pc = 32'h0000_0200;
        step(s, st, fl, rv, pc, rq);
        check("tp_abort_trap_pc", pc, 32'h0000_0200);
        check("tp_abort_req_held", {31'h0, rq}, 32'h1);
        s = quiet(); s.idone = 1'b1; s.ddone = 1'b1;
        step(s, st, fl, rv, pc, rq);
        check("tp_abort_req_last", {31'h0, rq}, 32'h1);
        step(quiet(), st, fl, rv, pc, rq);
        check("tp_abort_no_refetch", {31'h0, rv}, 32'h0);

        // Reset in the middle of TLB_FLUSH
        s = quiet(); s.sf = 1'b1; s.sf_pc = 32'h8000_2000;
        step(s, st, fl, rv, pc, rq);
        step(quiet(), st, fl, rv, pc, rq);
        @(negedge i_clk);
        apply(quiet());
        i_rst_n = 1'b0;
        #1;
        check("tp_rst_req_async", {31'h0, o_tlb_flush_req}, 32'h0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        s = quiet(); s.idone = 1'b1; s.ddone = 1'b1;
        step(s, st, fl, rv, pc, rq);
        step(quiet(), st, fl, rv, pc, rq);
        check("tp_rst_no_refetch", {31'h0, rv}, 32'h0);

        // Randomized traffic; branches and sfences only while the front end is live
        for (int c = 0; c < 2000; c++) begin
            s = quiet();
            for (int k = 0; k < 6; k++) s.ready[k] = ($urandom_range(0, 99) < 85);
            s.br      = !(m_waiting || m_refetch_due) && ($urandom_range(0, 99) < 20);
            s.br_tgt  = $urandom;
            s.trap    = ($urandom_range(0, 99) < 8);
            s.trap_pc = $urandom;
            s.sf      = !(m_waiting || m_refetch_due) && ($urandom_range(0, 99) < 12);
            s.sf_pc   = $urandom;
            s.idone   = ($urandom_range(0, 99) < 25);
            s.ddone   = ($urandom_range(0, 99) < 25);
            step(s, st, fl, rv, pc, rq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_letc_core_hazard_ctrl
